// File: rtl/noc_pkg.sv
// ============================================================================
//  Package : noc_pkg
//  Shared ring-NoC packet field positions, route and VC encodings.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_pkg;

  // Packet bit indices use big-endian numbering: index 0 is the packet MSB.
  localparam int c_vc_bit  = 0;
  localparam int c_dir_bit = 1;
  localparam int c_hop_hi  = 8;
  localparam int c_hop_lo  = 15;

  typedef enum logic [1:0] {
    DST_CW  = 2'b00,
    DST_CCW = 2'b01,
    DST_PE  = 2'b10
  } dst_e;

  typedef enum logic {
    VC_EVEN = 1'b0,
    VC_ODD  = 1'b1
  } vc_e;

endpackage

`default_nettype wire

// File: rtl/vc_slot.sv
// ============================================================================
//  Module  : vc_slot
//  Single-entry packet buffer with full flag for one virtual channel.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_slot #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_full,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_full;
  logic [DATA_WIDTH-1:0] r_data;

  // Write and read never target the same slot in one cycle; write wins anyway.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_we) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_re) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/ring_input_port.sv
// ============================================================================
//  Module  : ring_input_port
//  Router input port: per-VC single-entry buffers, polarity gating, routing.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_input_port
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int HOP_HI     = c_hop_hi,
  parameter int HOP_LO     = c_hop_lo
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  polarity,
  input  logic                  si,
  output logic                  ri,
  input  logic [DATA_WIDTH-1:0] di,
  output logic                  req,
  output logic [1:0]            req_dst,
  input  logic                  gnt,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  err_vc
);

  // Big-endian field indices mapped onto the descending bit vector.
  localparam int c_vc_pos  = DATA_WIDTH - 1 - c_vc_bit;
  localparam int c_dir_pos = DATA_WIDTH - 1 - c_dir_bit;
  localparam int c_hop_msb = DATA_WIDTH - 1 - HOP_HI;
  localparam int c_hop_lsb = DATA_WIDTH - 1 - HOP_LO;
  localparam int c_hop_w   = HOP_LO - HOP_HI + 1;

  logic                  w_lvc;
  logic                  w_dvc;
  logic                  w_accept;
  logic                  w_bad;
  logic [1:0]            w_we;
  logic [1:0]            w_re;
  logic [1:0]            w_full;
  logic [DATA_WIDTH-1:0] w_slot_data [2];
  logic [DATA_WIDTH-1:0] w_pkt;
  logic [DATA_WIDTH-1:0] w_upd;
  logic [c_hop_w-1:0]    w_hop;
  dst_e                  w_dst;
  logic                  r_err_vc;

  assign w_lvc    = polarity ? VC_EVEN : VC_ODD;
  assign w_dvc    = ~w_lvc;
  assign ri       = reset && !w_full[w_lvc];
  assign w_accept = si && ri && (di[c_vc_pos] == w_lvc);
  assign w_bad    = si && ri && (di[c_vc_pos] != w_lvc);

  for (genvar g = 0; g < 2; g++) begin : g_slot
    assign w_we[g] = w_accept && (int'(w_lvc) == g);
    assign w_re[g] = gnt && w_full[g] && (int'(w_dvc) == g);

    vc_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk    (clk),
      .reset  (reset),
      .i_we   (w_we[g]),
      .i_re   (w_re[g]),
      .i_data (di),
      .o_full (w_full[g]),
      .o_data (w_slot_data[g])
    );
  end

  // A zero hop count means the packet has reached its destination PE.
  always_comb begin
    w_pkt = w_slot_data[w_dvc];
    w_hop = w_pkt[c_hop_msb:c_hop_lsb];
    w_upd = w_pkt;
    w_dst = DST_PE;
    if (w_hop != '0) begin
      w_dst = w_pkt[c_dir_pos] ? DST_CCW : DST_CW;
      w_upd[c_hop_msb:c_hop_lsb] = w_hop >> 1;
    end
  end

  assign req     = w_full[w_dvc];
  assign dout    = req ? w_upd : '0;
  assign req_dst = req ? w_dst : DST_CW;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_vc <= 1'b0;
    end else if (w_bad) begin
      r_err_vc <= 1'b1;
    end
  end

  assign err_vc = r_err_vc;

endmodule

`default_nettype wire

// File: tb/tb_ring_input_port.sv
// ============================================================================
//  Module  : tb_ring_input_port
//  Directed self-checking bench for ring_input_port.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ring_input_port;

  logic        clk;
  logic        reset;
  logic        polarity;
  logic        si;
  logic        ri;
  logic [63:0] di;
  logic        req;
  logic [1:0]  req_dst;
  logic        gnt;
  logic [63:0] dout;
  logic        err_vc;

  int errors = 0;
  int checks = 0;

  // Packet bit 63 = VC, bit 62 = dir, bits 55:48 = hop (big-endian 8..15).
  localparam logic [63:0] P_A      = 64'h0040_0000_0000_00AA;
  localparam logic [63:0] P_A_UPD  = 64'h0020_0000_0000_00AA;
  localparam logic [63:0] P_B      = 64'hC000_0000_0000_0055;
  localparam logic [63:0] P_A2     = 64'h0010_0000_0000_0012;
  localparam logic [63:0] P_A2_UPD = 64'h0008_0000_0000_0012;

  logic [63:0] q_even_d [$];
  logic [1:0]  q_even_r [$];
  logic [63:0] q_odd_d  [$];
  logic [1:0]  q_odd_r  [$];

  ring_input_port dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .si       (si),
    .ri       (ri),
    .di       (di),
    .req      (req),
    .req_dst  (req_dst),
    .gnt      (gnt),
    .dout     (dout),
    .err_vc   (err_vc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    polarity = ~polarity;
  endtask

  function automatic logic [63:0] mk(input logic vc, input logic dir,
                                     input logic [7:0] hop, input logic [31:0] pay);
    return {vc, dir, 6'b0, hop, 16'h0, pay};
  endfunction

  initial begin
    logic        vc;
    logic        dir;
    logic [7:0]  hop;
    logic [63:0] pkt;
    logic [63:0] exp_d;
    logic [1:0]  exp_r;

    // 1: reset asserted while upstream drives
    reset = 1'b0; polarity = 1'b1; si = 1'b1; di = P_A; gnt = 1'b0;
    #2;
    chk("rst_ri", ri, 0);
    chk("rst_req", req, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dst", req_dst, 0);
    chk("rst_err", err_vc, 0);
    @(posedge clk); #1;
    chk("rst_edge_req", req, 0);
    reset = 1'b1; si = 1'b0;
    #1;
    chk("rel_ri", ri, 1);
    chk("rel_req", req, 0);

    // 2: even packet with hop 0x40 routed cw with hop halved
    si = 1'b1; di = P_A;
    tick(); si = 1'b0; #1;
    chk("t2_req", req, 1);
    chk("t2_dst", req_dst, 2'b00);
    chk("t2_dout", dout, P_A_UPD);
    chk("t2_ri_odd", ri, 1);
    gnt = 1'b1;
    tick(); gnt = 1'b0; #1;
    chk("t2_req_after_gnt", req, 0);
    chk("t2_dout_idle", dout, 0);
    chk("t2_ri_even", ri, 1);

    // 3: odd packet with hop 0 goes to local PE unchanged
    tick(); si = 1'b1; di = P_B; #1;
    chk("t3_ri", ri, 1);
    tick(); si = 1'b0; #1;
    chk("t3_req", req, 1);
    chk("t3_dst", req_dst, 2'b10);
    chk("t3_dout", dout, P_B);
    gnt = 1'b1;
    tick(); gnt = 1'b0; #1;
    chk("t3_req_after_gnt", req, 0);

    // 4: even slot held without grant, second packet back-pressured
    tick(); si = 1'b1; di = P_A;
    tick(); si = 1'b0; #1;
    chk("t4_req0", req, 1);
    chk("t4_dout0", dout, P_A_UPD);
    for (int i = 0; i < 6; i++) begin
      tick(); si = polarity; di = P_A2; #1;
      if (polarity) begin
        chk("t4_ri_blocked", ri, 0);
        chk("t4_req_odd_idle", req, 0);
      end else begin
        chk("t4_req_held", req, 1);
        chk("t4_dout_held", dout, P_A_UPD);
      end
    end
    if (polarity) begin
      tick(); si = 1'b0; #1;
    end
    si = 1'b0; gnt = 1'b1; #1;
    chk("t4_req_before_drain", req, 1);
    tick(); gnt = 1'b0; si = 1'b1; di = P_A2; #1;
    chk("t4_ri_reopened", ri, 1);
    tick(); si = 1'b0; #1;
    chk("t4_req2", req, 1);
    chk("t4_dout2", dout, P_A2_UPD);
    chk("t4_err_clear", err_vc, 0);
    gnt = 1'b1;
    tick(); gnt = 1'b0; #1;

    // 5: wrong-VC packet is dropped and flags a sticky error
    chk("t5_pol", polarity, 1);
    si = 1'b1; di = P_B; #1;
    chk("t5_ri", ri, 1);
    tick(); si = 1'b0; #1;
    chk("t5_err", err_vc, 1);
    chk("t5_no_even", req, 0);
    tick(); #1;
    chk("t5_no_odd", req, 0);
    tick(); tick(); #1;
    chk("t5_err_sticky", err_vc, 1);

    // 6: back-to-back alternating traffic with gnt held high
    gnt = 1'b1;
    for (int c = 0; c < 8; c++) begin
      vc  = polarity ? 1'b0 : 1'b1;
      dir = c[0];
      hop = 8'(c * 16);
      pkt = mk(vc, dir, hop, 32'(c + 100));
      si = 1'b1; di = pkt; #1;
      chk("t6_ri", ri, 1);
      if (c > 0) begin
        if (vc) begin
          exp_d = q_even_d.pop_front(); exp_r = q_even_r.pop_front();
        end else begin
          exp_d = q_odd_d.pop_front(); exp_r = q_odd_r.pop_front();
        end
        chk("t6_req", req, 1);
        chk("t6_dout", dout, exp_d);
        chk("t6_dst", req_dst, exp_r);
      end
      exp_d = mk(vc, dir, hop >> 1, 32'(c + 100));
      exp_r = (hop == 8'h00) ? 2'b10 : {1'b0, dir};
      if (vc) begin
        q_odd_d.push_back(exp_d); q_odd_r.push_back(exp_r);
      end else begin
        q_even_d.push_back(exp_d); q_even_r.push_back(exp_r);
      end
      tick();
    end
    si = 1'b0; #1;
    exp_d = (q_even_d.size() != 0) ? q_even_d.pop_front() : q_odd_d.pop_front();
    chk("t6_last_req", req, 1);
    chk("t6_last_dout", dout, exp_d);
    tick(); #1;
    chk("t6_drained", req, 0);
    chk("t6_queues_empty", 64'(q_even_d.size() + q_odd_d.size()), 0);

    // Async reset mid-transfer discards the in-flight packet
    gnt = 1'b0;
    si = 1'b1; di = polarity ? P_A : P_B;
    tick(); si = 1'b0; #1;
    chk("ar_req_before", req, 1);
    reset = 1'b0; #1;
    chk("ar_req", req, 0);
    chk("ar_dout", dout, 0);
    chk("ar_ri", ri, 0);
    chk("ar_err", err_vc, 0);
    tick(); reset = 1'b1; #1;
    chk("ar_empty_a", req, 0);
    tick(); #1;
    chk("ar_empty_b", req, 0);
    chk("ar_ri_after", ri, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
